// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-to-Wishbone bus master.
//   - Access size encodings used on cpu_size.
//   - Master FSM state type.
//   - Alignment check used when a request is accepted.
package cpu_bus_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic bad;
        case (size)
            SZ_HALF:  bad = addr_lo[0];
            SZ_WORD:  bad = |addr_lo[1:0];
            SZ_DWORD: bad = |addr_lo;
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu_bus_lane_steer.sv
// Combinational byte-lane steering for the bus master.
// Request side (from the CPU inputs):
//   req_off, req_size, req_wdata -> sel (byte select), wdata_steered (lane-aligned data)
// Response side (from registered transfer info):
//   rsp_off, rsp_size, rsp_signed, bus_rdata -> rdata_ext (right-aligned, extended)
module cpu_bus_lane_steer
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] req_off,
    input  logic [1:0]                  req_size,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [$clog2(DATA_W/8)-1:0] rsp_off,
    input  logic [1:0]                  rsp_size,
    input  logic                        rsp_signed,
    input  logic [DATA_W-1:0]           bus_rdata,
    output logic [DATA_W/8-1:0]         sel,
    output logic [DATA_W-1:0]           wdata_steered,
    output logic [DATA_W-1:0]           rdata_ext
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              sign_bit;

    // Enable 2^size contiguous lanes starting at the byte offset.
    always_comb begin
        sel           = LANES'((16'd1 << (5'd1 << req_size)) - 16'd1) << req_off;
        wdata_steered = req_wdata << {req_off, 3'b000};
    end

    // Bring the addressed bytes down to bit 0, keep only the access width and
    // fill the rest with copies of the top kept bit when a signed read asks for it.
    // A word on a 32-bit bus keeps every bit, so it never gets extended.
    always_comb begin
        shifted = bus_rdata >> {rsp_off, 3'b000};
        case (rsp_size)
            SZ_BYTE: begin
                keep     = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            SZ_HALF: begin
                keep     = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_WORD: begin
                keep     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                keep     = '1;
                sign_bit = 1'b0;
            end
        endcase
        rdata_ext = (shifted & keep) | ((rsp_signed && sign_bit) ? ~keep : '0);
    end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side master for a Wishbone classic bus, one transfer at a time.
// CPU side:  cpu_req/we/size/signed/addr/wdata in; cpu_rdata, cpu_ready (one-cycle
//            completion pulse) and cpu_err (failed transfer) out.
// Bus side:  wb_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o out; wb_dat_i/ack_i/err_i in.
// Misaligned or illegal-size requests fail without a bus cycle; a watchdog aborts
// bus cycles that get no ack/err within TIMEOUT cycles (TIMEOUT = 0 disables it).
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [1:0]          cpu_size,
    input  logic                cpu_signed,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The abort fires on the cycle whose increment would make the count reach TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [OFF_W-1:0]  off_q;
    logic [CNT_W-1:0]  count;

    logic [LANES-1:0]  steer_sel;
    logic [DATA_W-1:0] steer_wdata;
    logic [DATA_W-1:0] steer_rdata;
    logic              access_bad;
    logic              timed_out;

    assign access_bad = ((cpu_size == SZ_DWORD) && (DATA_W == 32)) ||
                        is_misaligned(cpu_size, cpu_addr[2:0]);
    assign timed_out  = (TIMEOUT != 0) && (count == TO_LAST);

    // Write steering works on the live CPU inputs so sel/data can be registered as the
    // request is taken; read extraction uses the offset/size captured with it.
    cpu_bus_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .req_off       (cpu_addr[OFF_W-1:0]),
        .req_size      (cpu_size),
        .req_wdata     (cpu_wdata),
        .rsp_off       (off_q),
        .rsp_size      (size_q),
        .rsp_signed    (signed_q),
        .bus_rdata     (wb_dat_i),
        .sel           (steer_sel),
        .wdata_steered (steer_wdata),
        .rdata_ext     (steer_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            size_q    <= '0;
            signed_q  <= 1'b0;
            off_q     <= '0;
            count     <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= '0;
            wb_dat_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    if (cpu_req) begin
                        size_q   <= cpu_size;
                        signed_q <= cpu_signed;
                        off_q    <= cpu_addr[OFF_W-1:0];
                        if (access_bad) begin
                            state     <= ST_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                        end else begin
                            state    <= ST_BUS;
                            count    <= '0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= cpu_we;
                            wb_adr_o <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            wb_sel_o <= steer_sel;
                            wb_dat_o <= steer_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    if (wb_err_i || wb_ack_i || timed_out) begin
                        state     <= ST_RESP;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        cpu_ready <= 1'b1;
                        // A bus error beats an ack in the same cycle; an ack beats the watchdog.
                        cpu_err   <= wb_err_i || !wb_ack_i;
                        if (wb_ack_i && !wb_err_i && !wb_we_o) begin
                            cpu_rdata <= steer_rdata;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: a 32-bit instance (TIMEOUT = 4) and a
// 64-bit instance (TIMEOUT = 6) driven by directed and randomized transfers, with
// expected bus signals, latency and read data computed by an arithmetic model.
module tb_cpu_bus_master;

   localparam int TO32 = 4;
   localparam int TO64 = 6;

   logic clk = 1'b0;
   logic resetN;

   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        aReq, aWe, aSigned, aReady, aErr, aCyc, aStb, aWbWe, aAck, aErrIn;
   logic [1:0]  aSize;
   logic [31:0] aAddr, aWdata, aRdata, aAdr, aDatO, aDatI;
   logic [3:0]  aSel;

   // 64-bit instance signals
   logic        bReq, bWe, bSigned, bReady, bErr, bCyc, bStb, bWbWe, bAck, bErrIn;
   logic [1:0]  bSize;
   logic [31:0] bAddr, bAdr;
   logic [63:0] bWdata, bRdata, bDatO, bDatI;
   logic [7:0]  bSel;

   cpu_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) dut32 (
      .clk(clk), .reset(resetN),
      .cpu_req(aReq), .cpu_we(aWe), .cpu_size(aSize), .cpu_signed(aSigned),
      .cpu_addr(aAddr), .cpu_wdata(aWdata), .cpu_rdata(aRdata),
      .cpu_ready(aReady), .cpu_err(aErr),
      .wb_cyc_o(aCyc), .wb_stb_o(aStb), .wb_we_o(aWbWe), .wb_adr_o(aAdr),
      .wb_sel_o(aSel), .wb_dat_o(aDatO), .wb_dat_i(aDatI),
      .wb_ack_i(aAck), .wb_err_i(aErrIn)
   );

   cpu_bus_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) dut64 (
      .clk(clk), .reset(resetN),
      .cpu_req(bReq), .cpu_we(bWe), .cpu_size(bSize), .cpu_signed(bSigned),
      .cpu_addr(bAddr), .cpu_wdata(bWdata), .cpu_rdata(bRdata),
      .cpu_ready(bReady), .cpu_err(bErr),
      .wb_cyc_o(bCyc), .wb_stb_o(bStb), .wb_we_o(bWbWe), .wb_adr_o(bAdr),
      .wb_sel_o(bSel), .wb_dat_o(bDatO), .wb_dat_i(bDatI),
      .wb_ack_i(bAck), .wb_err_i(bErrIn)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   logic [63:0] expRd32, expRd64;

   logic        oCyc, oStb, oWe, oReady, oErr;
   logic [63:0] oAdr, oSel, oDat, oRdata;

   // One comparison: counted, and reported with observed/expected when it misses.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Snapshot the outputs of one instance into width-neutral variables.
   task automatic grab(input bit is64);
      if (is64) begin
         oCyc = bCyc; oStb = bStb; oWe = bWbWe; oReady = bReady; oErr = bErr;
         oAdr = 64'(bAdr); oSel = 64'(bSel); oDat = bDatO; oRdata = bRdata;
      end else begin
         oCyc = aCyc; oStb = aStb; oWe = aWbWe; oReady = aReady; oErr = aErr;
         oAdr = 64'(aAdr); oSel = 64'(aSel); oDat = 64'(aDatO); oRdata = 64'(aRdata);
      end
   endtask

   task automatic driveReq(input bit is64, input logic req, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [63:0] wdata);
      if (is64) begin
         bReq = req; bWe = we; bSize = size; bSigned = sgn; bAddr = addr; bWdata = wdata;
      end else begin
         aReq = req; aWe = we; aSize = size; aSigned = sgn; aAddr = addr; aWdata = wdata[31:0];
      end
   endtask

   task automatic setReq(input bit is64, input logic req);
      if (is64) bReq = req;
      else aReq = req;
   endtask

   task automatic driveSlave(input bit is64, input logic ack, input logic err, input logic [63:0] dat);
      if (is64) begin
         bAck = ack; bErrIn = err; bDatI = dat;
      end else begin
         aAck = ack; aErrIn = err; aDatI = dat[31:0];
      end
   endtask

   // Read result from the size/offset/sign rules: pick the addressed bytes, keep the
   // access width, sign-fill up to the bus width when asked and narrower than the bus.
   function automatic logic [63:0] modelRead(input bit is64, input logic [1:0] size, input logic sgn,
                                             input int off, input logic [63:0] bus);
      int nbits = 8 * (1 << size);
      int dw = is64 ? 64 : 32;
      logic [63:0] v = bus >> (8 * off);
      if (nbits < 64) v &= (64'd1 << nbits) - 64'd1;
      if (sgn && nbits < dw && v[nbits-1]) v |= ~((64'd1 << nbits) - 64'd1);
      if (!is64) v &= 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   // One complete transfer with a slave that answers per 'kind' after 'waits' idle
   // strobe cycles: 0 = ack, 1 = err, 2 = ack+err, 3 = never answers.
   // preheld: the request is already being held from the previous call.
   // hold: keep cpu_req high through the whole transfer.
   task automatic applyStimulus(input bit is64, input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [63:0] wdata, input int kind,
                                input int waits, input logic [63:0] bus, input bit preheld,
                                input bit hold, input string tag);
      int to, lanes, nbytes, off, respC, readyC;
      bit legal;
      logic [63:0] dmask, expSel, expDat, expAdr, expRd;
      to     = is64 ? TO64 : TO32;
      lanes  = is64 ? 8 : 4;
      dmask  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      nbytes = 1 << size;
      off    = int'(addr % lanes);
      legal  = !(size == 2'd3 && !is64) && (addr % nbytes == 0);
      expSel = ((64'd1 << nbytes) - 64'd1) << off;
      expDat = (wdata << (8 * off)) & dmask;
      expAdr = 64'(addr) - 64'(off);
      bus    = bus & dmask;

      if (!preheld) begin
         @(posedge clk); #1;
      end
      driveReq(is64, 1'b1, we, size, sgn, addr, wdata);
      @(posedge clk); #1;
      if (!hold) setReq(is64, 1'b0);

      if (!legal) begin
         @(negedge clk); grab(is64);
         checkOutput($sformatf("%s.noCyc", tag), 64'({oCyc, oStb}), 64'd0);
         checkOutput($sformatf("%s.rdy", tag), 64'(oReady), 64'd1);
         checkOutput($sformatf("%s.err", tag), 64'(oErr), 64'd1);
         checkOutput($sformatf("%s.rdataKept", tag), oRdata, is64 ? expRd64 : expRd32);
      end else begin
         respC  = (kind == 3) ? 0 : 1 + waits;
         readyC = (kind == 3) ? to + 1 : respC + 1;
         for (int c = 1; c <= readyC; c++) begin
            if (c > 1) begin
               @(posedge clk); #1;
            end
            if (c == respC) driveSlave(is64, kind == 0 || kind == 2, kind == 1 || kind == 2, bus);
            else driveSlave(is64, 1'b0, 1'b0, {$urandom, $urandom});
            @(negedge clk); grab(is64);
            if (c == 1) begin
               checkOutput($sformatf("%s.we", tag), 64'(oWe), 64'(we));
               checkOutput($sformatf("%s.adr", tag), oAdr, expAdr);
               checkOutput($sformatf("%s.sel", tag), oSel, expSel);
               checkOutput($sformatf("%s.dat", tag), oDat, expDat);
            end
            checkOutput($sformatf("%s.c%0d.cycStb", tag, c), 64'({oCyc, oStb}),
                        (c < readyC) ? 64'd3 : 64'd0);
            checkOutput($sformatf("%s.c%0d.rdy", tag, c), 64'(oReady), 64'(c == readyC));
         end
         if (kind == 0 && !we) begin
            expRd = modelRead(is64, size, sgn, off, bus);
            if (is64) expRd64 = expRd;
            else expRd32 = expRd;
         end
         checkOutput($sformatf("%s.err", tag), 64'(oErr), 64'(kind != 0));
         checkOutput($sformatf("%s.rdata", tag), oRdata, is64 ? expRd64 : expRd32);
      end

      // The cycle after the pulse is IDLE: pulse gone and no bus cycle, even if cpu_req is held.
      @(posedge clk); #1;
      driveSlave(is64, 1'b0, 1'b0, 64'd0);
      @(negedge clk); grab(is64);
      checkOutput($sformatf("%s.idleRdy", tag), 64'(oReady), 64'd0);
      checkOutput($sformatf("%s.idleCyc", tag), 64'({oCyc, oStb}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         is64;
      int         kind;
      int         waits;
      int         k;

      resetN = 1'b0;
      driveReq(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
      driveReq(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0);
      driveSlave(1'b0, 1'b0, 1'b0, 64'd0);
      driveSlave(1'b1, 1'b0, 1'b0, 64'd0);
      expRd32 = 64'd0;
      expRd64 = 64'd0;

      // Reset state of both instances
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         grab(i == 1);
         checkOutput($sformatf("rst%0d.ctrl", i), 64'({oCyc, oStb, oWe, oReady, oErr}), 64'd0);
         checkOutput($sformatf("rst%0d.adr", i), oAdr, 64'd0);
         checkOutput($sformatf("rst%0d.sel", i), oSel, 64'd0);
         checkOutput($sformatf("rst%0d.dat", i), oDat, 64'd0);
         checkOutput($sformatf("rst%0d.rdata", i), oRdata, 64'd0);
      end
      resetN = 1'b1;

      // Directed transfers on the 32-bit bus
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 64'hDEAD_BEEF, 0, 1, 64'd0, 1'b0, 1'b0, "wordWrite");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 0, 0, 64'h80FF_0000, 1'b0, 1'b0, "sByteRead");
      checkOutput("sByteConst", 64'(aRdata), 64'hFFFF_FF80);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 64'd0, 0, 0, 64'h80FF_0000, 1'b0, 1'b0, "uByteRead");
      checkOutput("uByteConst", 64'(aRdata), 64'h0000_0080);
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 64'h1234, 0, 0, 64'd0, 1'b0, 1'b0, "halfWrite");
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 32'h101, 64'd0, 0, 0, 64'd0, 1'b0, 1'b0, "halfMisalign");
      applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 32'h108, 64'd0, 0, 0, 64'd0, 1'b0, 1'b0, "dwordOn32");
      applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 64'd0, 3, 0, 64'd0, 1'b0, 1'b0, "timeout32");
      applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h204, 64'd0, 0, 2, 64'hCAFE_F00D, 1'b0, 1'b0, "afterTimeout");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 32'h205, 64'd0, 2, 0, 64'h0000_9900, 1'b0, 1'b0, "ackAndErr");
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 32'h302, 64'd0, 0, 2, 64'hF00D_0000, 1'b0, 1'b1, "heldReq");
      applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 32'h300, 64'd0, 0, 0, 64'h0000_8123, 1'b1, 1'b0, "heldNext");

      // Reset pulled low in the middle of a bus cycle
      @(posedge clk); #1;
      driveReq(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 64'd0);
      @(posedge clk); #1;
      setReq(1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); grab(1'b0);
      checkOutput("midRst.preStb", 64'({oCyc, oStb}), 64'd3);
      #1 resetN = 1'b0;
      #1 grab(1'b0);
      checkOutput("midRst.asyncDrop", 64'({oCyc, oStb}), 64'd0);
      expRd32 = 64'd0;
      expRd64 = 64'd0;
      @(posedge clk);
      @(negedge clk); grab(1'b0);
      checkOutput("midRst.noRdy", 64'(oReady), 64'd0);
      resetN = 1'b1;
      @(negedge clk); grab(1'b0);
      checkOutput("midRst.idle", 64'({oCyc, oStb, oReady}), 64'd0);
      checkOutput("midRst.rdata", oRdata, 64'd0);
      applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h404, 64'd0, 0, 0, 64'h1357_9BDF, 1'b0, 1'b0, "postRst");

      // Directed transfers on the 64-bit bus
      applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 64'd0, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, "dwordRead");
      checkOutput("dwordConst", bRdata, 64'h0123_4567_89AB_CDEF);
      applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h4, 64'd0, 0, 0, 64'd0, 1'b0, 1'b0, "dwordMisalign");
      applyStimulus(1'b1, 1'b0, 2'd2, 1'b1, 32'h4, 64'd0, 0, 1, 64'h8000_0001_0000_0000, 1'b0, 1'b0, "sWord64");
      applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 32'h5, 64'hA5, 0, 0, 64'd0, 1'b0, 1'b0, "byteWrite64");
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 64'h1111_2222, 3, 0, 64'd0, 1'b0, 1'b0, "timeout64");

      // Randomized transfers on either bus width
      for (int i = 0; i < 40; i++) begin
         is64  = 1'($urandom_range(0, 1));
         k     = int'($urandom_range(0, 9));
         kind  = (k < 7) ? 0 : k - 6;
         waits = int'($urandom_range(0, (is64 ? TO64 : TO32) - 2));
         applyStimulus(is64, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'h1000 + 32'($urandom_range(0, 31)), {$urandom, $urandom}, kind, waits,
                       {$urandom, $urandom}, 1'b0, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Parametrised successor to the CPU's ad-hoc memory strobe/ready interface (MemRead/MemWrite/MIO_ready).
- Sits between the multi-cycle CPU core and the Wishbone classic bus and runs one transfer at a time.
- Adds byte-lane steering for byte/half/word(/dword) accesses, sign/zero extension of read data, misalignment detection and a bus-timeout watchdog.
- Returns a one-cycle ready pulse to the CPU, which replaces MIO_ready.

Parameters:
- DATA_W, 32, bus data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, cycles to wait for ack/err before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  transfer request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = dword (dword legal only when DATA_W = 64).
- cpu_signed  in  1  sign-extend read data (byte/half reads; also word reads when DATA_W = 64).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data, right-aligned.
- cpu_rdata  out  DATA_W  read data, right-aligned and extended.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  high together with cpu_ready when the transfer failed.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  ADDR_W  address, aligned to DATA_W/8 bytes.
- wb_sel_o  out  DATA_W/8  byte select.
- wb_dat_o  out  DATA_W  write data, steered to the addressed lanes.
- wb_dat_i  in  DATA_W  read data.
- wb_ack_i  in  1  bus acknowledge.
- wb_err_i  in  1  bus error.

Behaviour:
- Reset (reset = 0, async): state = IDLE. All outputs are 0, including cpu_rdata, wb_adr_o, wb_sel_o and wb_dat_o. The timeout counter is 0.
- FSM states: IDLE, BUS, RESP.
- IDLE with cpu_req = 1:
  - Register we, size, signed, addr and wdata.
  - If the access is misaligned or the size is illegal: go to RESP with err = 1 and issue no bus cycle.
  - Otherwise go to BUS. From the next cycle, wb_cyc_o = wb_stb_o = 1 and address/sel/data are stable.
- Misaligned: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; dword with addr[2:0] ≠ 0. Size 11 is illegal when DATA_W = 32.
- Lane steering, with L = DATA_W/8 and off = addr mod L:
  - wb_sel_o = ((1 << bytes) − 1) << off, where bytes = 1 << size.
  - wb_dat_o = wdata shifted left by 8·off.
  - wb_adr_o = addr with the low log2(L) bits cleared.
- BUS:
  - wb_ack_i = 1: capture wb_dat_i >> 8·off, truncate to the access size, extend per the signed flag. Drop cyc/stb in the same clock edge and go to RESP with err = 0.
  - wb_err_i = 1: go to RESP with err = 1; cpu_rdata is unchanged.
  - ack and err both high: err wins.
  - Timeout counter increments each BUS cycle. When it reaches TIMEOUT (with TIMEOUT ≠ 0): drop cyc/stb and go to RESP with err = 1.
  - Counter clears on entry to BUS.
- RESP: cpu_ready = 1 for exactly one cycle and cpu_err = err; then IDLE.
- cpu_rdata holds its value until the next successful read. Writes leave cpu_rdata unchanged.
- Latency: request at cycle 0 → strobe visible at cycle 1. Ack at cycle n → cpu_ready at cycle n+1.
  - Minimum turnaround: 3 cycles for a zero-wait-state slave.
- cpu_req is ignored outside IDLE. A request held high in the RESP cycle is not taken until IDLE.
- Reset asserted mid-transfer: cyc/stb drop immediately (async); no cpu_ready is produced.

Decomposition:
- Shared package (cpu_bus_pkg):
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - FSM state encoding;
  - a function for misalignment check.
- One sub-module: cpu_bus_lane_steer. It is combinational and does sel generation, write-data shift and read-data extract/extend, parametrised on DATA_W.
- The FSM and timeout counter stay in cpu_bus_master.

Test Plan:
- Word write, DATA_W = 32, addr 0x100, wdata 0xDEADBEEF, slave acks one cycle after stb → sel = 1111, adr = 0x100, dat_o = 0xDEADBEEF; cpu_ready pulse on cycle 3 with cpu_err = 0.
- Signed byte read, addr 0x103, slave returns 0x80FF_0000 → sel = 1000, cpu_rdata = 0xFFFFFF80. Same read with cpu_signed = 0 → cpu_rdata = 0x00000080.
- Half write at addr 0x102, wdata 0x1234 → sel = 1100, dat_o = 0x12340000. Half read at addr 0x101 → no cyc; cpu_ready with cpu_err = 1 one cycle later.
- TIMEOUT = 4, slave never responds → stb high for 4 cycles, then dropped; cpu_ready with cpu_err = 1. Next request proceeds normally.
- Slave asserts ack and err together → cpu_err = 1, cpu_rdata unchanged. Reset pulled low during BUS → cyc/stb = 0 at once, no cpu_ready; after release, state is IDLE.
- DATA_W = 64, dword read at addr 0x8 → sel = 0xFF; cpu_rdata = wb_dat_i. Dword read at 0x4 → misalign error with no bus cycle.
